amba_axi4_lite_reg_slave: RTL and testbench
===========================================

# amba_axi4_lite_reg_slave

- AXI4-Lite subordinate: a bank of `NUM_REGS` data-width registers with byte-strobe writes.
- Sits directly downstream of a manager on the AW/W/B/AR/R interface; it is the design that `amba_axi4_protocol_checker` is bound to in destination mode (`TYPE=1`).
- Write address and write data are accepted independently, in either order or in the same cycle.
- Each access gets exactly one response. Out-of-range accesses get an error response and are discarded.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 32: address bus width.
- `DATA_WIDTH`, 64: data bus width; must be 32 or 64.
- `NUM_REGS`, 16: register count; must be a power of two and ≥ 2.
- `STRB_WIDTH` (localparam) = `DATA_WIDTH/8`.

Ports:
- `ACLK` in 1: clock; all logic on the rising edge.
- `ARESETn` in 1: asynchronous, active-low reset.
- `AWVALID`/`AWREADY` in/out 1; `AWADDR` in `ADDRESS_WIDTH`; `AWPROT` in 3: write address channel.
- `WVALID`/`WREADY` in/out 1; `WDATA` in `DATA_WIDTH`; `WSTRB` in `STRB_WIDTH`: write data channel.
- `BVALID` out 1; `BREADY` in 1; `BRESP` out `responses_t`: write response.
- `ARVALID`/`ARREADY` in/out 1; `ARADDR` in `ADDRESS_WIDTH`; `ARPROT` in 3: read address channel.
- `RVALID` out 1; `RREADY` in 1; `RDATA` out `DATA_WIDTH`; `RRESP` out 2: read response.

## Operation
- **Decode**
  - `OFS = log2(STRB_WIDTH)`.
  - Index = `ADDR[OFS +: log2(NUM_REGS)]`; the low `OFS` bits are ignored.
  - In range iff `ADDR < NUM_REGS*STRB_WIDTH`; otherwise the response is DECERR.
- **Write path**
  - Flags `aw_held` / `w_held` latch a handshaken beat that was not committed in the same cycle.
  - `AWREADY = rst_done & ~aw_held`; `WREADY = rst_done & ~w_held`. Both are registered-state-only; there is no combinational path from any VALID.
  - Commit fires when all three hold:
    - address is available (`aw_held`, or `AWVALID&AWREADY`);
    - data is available (`w_held`, or `WVALID&WREADY`);
    - B slot is free (`~BVALID | BREADY`).
  - On commit:
    - in range: byte `i` of the register is updated iff `WSTRB[i]`, and `BRESP`=OKAY;
    - out of range: no update, `BRESP`=DECERR;
    - `BVALID` is set and both held flags clear.
  - When the B slot is blocked, a beat arriving in that cycle is latched into its held flag.
- **Read path**
  - `ARREADY = rst_done & ~RVALID`.
  - On AR handshake, the next cycle has `RVALID`=1 with:
    - in range: `RDATA` = register value as it was before that clock edge, `RRESP`=OKAY;
    - out of range: `RDATA`=0, `RRESP`=DECERR.
  - `RDATA`/`RRESP` are stable while `RVALID && !RREADY`.
- **Channel independence**
  - The read and write paths are independent.
  - A read and a write commit to the same register in the same cycle return the old value.
- **Reset**
  - `rst_done` goes to 1 on the first edge after `ARESETn` deasserts.
  - Reset asserted mid-transaction drops all held beats and pending responses immediately, and clears every register to 0.

## Timing
- Reset values:
  - `AWREADY`/`WREADY`/`ARREADY`/`BVALID`/`RVALID` = 0;
  - `BRESP`=OKAY; `RRESP`=OKAY; `RDATA`=0;
  - all registers 0.
- AW and W handshaken in the same cycle with `BVALID`=0: register updated at that edge, `BVALID`=1 the following cycle (latency 1).
- AW at cycle N, W at cycle N+k: commit at cycle N+k, `BVALID` at N+k+1. `AWREADY` is low during cycles N+1 through N+k.
- `BVALID` stays high until `BREADY`. With `BREADY` held high, the sustained write throughput is 1 per cycle.
- Read latency is 1 cycle. Throughput is 1 read per 2 cycles, because `ARREADY` is low while `RVALID` is high.
- VALID signals are never required to wait for READY. Once asserted, `BVALID`/`RVALID` never drop without their handshake.

## Configuration
- `AXI4_LITE_SLAVE_PROT_CHECK_EN`
- Defined:
  - a write with `AWPROT[0]`=0 (unprivileged) commits with no register update and `BRESP`=SLVERR;
  - a read with `ARPROT[0]`=0 returns `RDATA`=0 and `RRESP`=SLVERR;
  - DECERR takes priority over SLVERR.
- Undefined: `AWPROT`/`ARPROT` are ignored.

## Structure
- Shared package `amba_axi4_pkg`:
  - `responses_t` enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - `PROT_PRIV_BIT`=0.
- Sub-module `amba_axi4_lite_reg_array`:
  - contains the register storage, the byte-strobe merge and the combinational read mux;
  - ports: `ACLK`, `ARESETn`, `we`, `widx`, `wdata`, `wstrb`, `ridx`, `rdata`.
- Top level holds the held flags, the commit logic, the response registers and `rst_done`.

## Test plan
- **Same-cycle write:** `AWADDR`=0x08, `WDATA`=0x1122334455667788, `WSTRB`=0xFF with `BREADY`=1 → next cycle `BVALID`=1, `BRESP`=OKAY; a read of 0x08 returns 0x1122334455667788.
- **W-before-AW:** W to reg 3 with `WSTRB`=0x0F at cycle 2; AW 0x18 at cycle 5 → `WREADY`=0 for cycles 3–5, `BVALID` at cycle 6; the upper 4 bytes of reg 3 stay 0.
- **B backpressure:** `BREADY`=0 for 4 cycles after a write, then a second AW/W pair presented → second commit waits; `BVALID`/`BRESP` stable; the second response appears the cycle after the first B handshake.
- **Out of range:** read 0x80 with `NUM_REGS`=16 → `RRESP`=DECERR, `RDATA`=0; write 0x80 → DECERR and no register changes.
- **Protection (macro defined):** `AWPROT`=3'b000 write to 0x00 → SLVERR, reg 0 unchanged; with `AWPROT`=3'b001 → OKAY.
- **Reset mid-transaction:** drop `ARESETn` while `BVALID`=1 and AW is held → all outputs return to reset values asynchronously; a read after release returns 0.

Source files
------------

// File: rtl/amba_axi4_pkg.sv
`default_nettype none
// ============================================================================
// amba_axi4_pkg -- AXI4 response encodings and protection bit positions. rev 1.0
// ============================================================================
package amba_axi4_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } responses_t;

    localparam int PROT_PRIV_BIT = 0;

    // Decode errors outrank protection errors.
    function automatic responses_t access_resp(input logic in_range, input logic priv_ok);
        if (!in_range) begin
            return DECERR;
        end
        if (!priv_ok) begin
            return SLVERR;
        end
        return OKAY;
    endfunction

endpackage
`default_nettype wire

// File: rtl/amba_axi4_lite_reg_array.sv
`default_nettype none
// ============================================================================
// amba_axi4_lite_reg_array -- register storage, byte-strobe merge, async read mux. rev 1.0
// ============================================================================
module amba_axi4_lite_reg_array
    import amba_axi4_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REGS   = 16
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    input  logic                          we,
    input  logic [$clog2(NUM_REGS)-1:0]   widx,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic [DATA_WIDTH/8-1:0]       wstrb,
    input  logic [$clog2(NUM_REGS)-1:0]   ridx,
    output logic [DATA_WIDTH-1:0]         rdata
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_WIDTH  = $clog2(NUM_REGS);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else if (we) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (widx == IDX_WIDTH'(r)) begin
                    for (int b = 0; b < STRB_WIDTH; b++) begin
                        if (wstrb[b]) begin
                            regs[r][b*8 +: 8] <= wdata[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Combinational so a same-edge read returns the pre-write value.
    assign rdata = regs[ridx];

endmodule
`default_nettype wire

// File: rtl/amba_axi4_lite_reg_slave.sv
`default_nettype none
// ============================================================================
// amba_axi4_lite_reg_slave -- AXI4-Lite register bank subordinate; optional
// privilege checking with AXI4_LITE_SLAVE_PROT_CHECK_EN. rev 1.0
// ============================================================================
module amba_axi4_lite_reg_slave
    import amba_axi4_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 64,
    parameter int NUM_REGS      = 16,
    localparam int STRB_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    // write address
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [ADDRESS_WIDTH-1:0]  AWADDR,
    input  logic [2:0]                AWPROT,
    // write data
    input  logic                      WVALID,
    output logic                      WREADY,
    input  logic [DATA_WIDTH-1:0]     WDATA,
    input  logic [STRB_WIDTH-1:0]     WSTRB,
    // write response
    output logic                      BVALID,
    input  logic                      BREADY,
    output responses_t                BRESP,
    // read address
    input  logic                      ARVALID,
    output logic                      ARREADY,
    input  logic [ADDRESS_WIDTH-1:0]  ARADDR,
    input  logic [2:0]                ARPROT,
    // read data
    output logic                      RVALID,
    input  logic                      RREADY,
    output logic [DATA_WIDTH-1:0]     RDATA,
    output logic [1:0]                RRESP
);

    localparam int OFS       = $clog2(STRB_WIDTH);
    localparam int IDX_WIDTH = $clog2(NUM_REGS);
    localparam int TOP_LSB   = OFS + IDX_WIDTH;

    logic                     rst_done;
    logic                     aw_held;
    logic                     w_held;
    logic [ADDRESS_WIDTH-1:0] aw_addr_q;
    logic [2:0]               aw_prot_q;
    logic [DATA_WIDTH-1:0]    w_data_q;
    logic [STRB_WIDTH-1:0]    w_strb_q;

    logic                     aw_hs;
    logic                     w_hs;
    logic                     ar_hs;
    logic                     commit;
    logic [ADDRESS_WIDTH-1:0] wr_addr;
    logic [2:0]               wr_prot;
    logic [DATA_WIDTH-1:0]    wr_data;
    logic [STRB_WIDTH-1:0]    wr_strb;
    logic                     wr_in_range;
    logic                     rd_in_range;
    logic                     wr_priv;
    logic                     rd_priv;
    responses_t               wr_resp;
    responses_t               rd_resp;
    logic                     reg_we;
    logic [DATA_WIDTH-1:0]    reg_rdata;
    logic                     unused_bits;

    // READY depends on registered state only, never on the VALIDs.
    assign AWREADY = rst_done & ~aw_held;
    assign WREADY  = rst_done & ~w_held;
    assign ARREADY = rst_done & ~RVALID;

    assign aw_hs = AWVALID & AWREADY;
    assign w_hs  = WVALID  & WREADY;
    assign ar_hs = ARVALID & ARREADY;

    assign wr_addr = aw_held ? aw_addr_q : AWADDR;
    assign wr_prot = aw_held ? aw_prot_q : AWPROT;
    assign wr_data = w_held  ? w_data_q  : WDATA;
    assign wr_strb = w_held  ? w_strb_q  : WSTRB;

    assign commit = (aw_held | aw_hs) & (w_held | w_hs) & (~BVALID | BREADY);

    assign wr_in_range = (wr_addr[ADDRESS_WIDTH-1:TOP_LSB] == '0);
    assign rd_in_range = (ARADDR[ADDRESS_WIDTH-1:TOP_LSB] == '0);

`ifdef AXI4_LITE_SLAVE_PROT_CHECK_EN
    assign wr_priv = wr_prot[PROT_PRIV_BIT];
    assign rd_priv = ARPROT[PROT_PRIV_BIT];
`else
    assign wr_priv = 1'b1;
    assign rd_priv = 1'b1;
`endif

    assign wr_resp = access_resp(wr_in_range, wr_priv);
    assign rd_resp = access_resp(rd_in_range, rd_priv);
    assign reg_we  = commit & (wr_resp == OKAY);

    // Byte-offset bits and unchecked protection bits carry no meaning here.
    assign unused_bits = ^{wr_prot, ARPROT, wr_addr[OFS-1:0], ARADDR[OFS-1:0]};

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rst_done  <= 1'b0;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            aw_prot_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            BVALID    <= 1'b0;
            BRESP     <= OKAY;
        end else begin
            rst_done <= 1'b1;
            if (aw_hs) begin
                aw_addr_q <= AWADDR;
                aw_prot_q <= AWPROT;
            end
            if (w_hs) begin
                w_data_q <= WDATA;
                w_strb_q <= WSTRB;
            end
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                BVALID  <= 1'b1;
                BRESP   <= wr_resp;
            end else begin
                // Beats that cannot commit yet wait in the held registers.
                if (aw_hs) begin
                    aw_held <= 1'b1;
                end
                if (w_hs) begin
                    w_held <= 1'b1;
                end
                if (BREADY) begin
                    BVALID <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            RVALID <= 1'b0;
            RDATA  <= '0;
            RRESP  <= OKAY;
        end else if (ar_hs) begin
            RVALID <= 1'b1;
            RDATA  <= (rd_resp == OKAY) ? reg_rdata : '0;
            RRESP  <= rd_resp;
        end else if (RREADY) begin
            RVALID <= 1'b0;
        end
    end

    amba_axi4_lite_reg_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_reg_array (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .we      (reg_we),
        .widx    (wr_addr[OFS +: IDX_WIDTH]),
        .wdata   (wr_data),
        .wstrb   (wr_strb),
        .ridx    (ARADDR[OFS +: IDX_WIDTH]),
        .rdata   (reg_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_amba_axi4_lite_reg_slave.sv
`default_nettype none
// ============================================================================
// tb_amba_axi4_lite_reg_slave -- randomized bench against a flat array model. rev 1.0
// ============================================================================
module tb_amba_axi4_lite_reg_slave;
    import amba_axi4_pkg::*;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int NR = 16;
    localparam int SW = DW / 8;
`ifdef AXI4_LITE_SLAVE_PROT_CHECK_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b0;
    logic          AWVALID = 1'b0;
    logic          AWREADY;
    logic [AW-1:0] AWADDR = '0;
    logic [2:0]    AWPROT = '0;
    logic          WVALID = 1'b0;
    logic          WREADY;
    logic [DW-1:0] WDATA = '0;
    logic [SW-1:0] WSTRB = '0;
    logic          BVALID;
    logic          BREADY = 1'b0;
    responses_t    BRESP;
    logic          ARVALID = 1'b0;
    logic          ARREADY;
    logic [AW-1:0] ARADDR = '0;
    logic [2:0]    ARPROT = '0;
    logic          RVALID;
    logic          RREADY = 1'b0;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] model [NR];

    always #5 ACLK = ~ACLK;

    amba_axi4_lite_reg_slave #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .NUM_REGS      (NR)
    ) dut (
        .ACLK (ACLK), .ARESETn (ARESETn),
        .AWVALID (AWVALID), .AWREADY (AWREADY), .AWADDR (AWADDR), .AWPROT (AWPROT),
        .WVALID (WVALID), .WREADY (WREADY), .WDATA (WDATA), .WSTRB (WSTRB),
        .BVALID (BVALID), .BREADY (BREADY), .BRESP (BRESP),
        .ARVALID (ARVALID), .ARREADY (ARREADY), .ARADDR (ARADDR), .ARPROT (ARPROT),
        .RVALID (RVALID), .RREADY (RREADY), .RDATA (RDATA), .RRESP (RRESP)
    );

    // ---------------- reference model ----------------
    function automatic logic [1:0] m_resp(input logic [AW-1:0] a, input logic [2:0] p);
        if (a >= AW'(NR * SW)) return 2'b11;
        if (PROT_EN && !p[0]) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int m_idx(input logic [AW-1:0] a);
        return int'((a / AW'(SW)) % AW'(NR));
    endfunction

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a, input logic [2:0] p);
        if (m_resp(a, p) != 2'b00) return '0;
        return model[m_idx(a)];
    endfunction

    task automatic m_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s, input logic [2:0] p);
        if (m_resp(a, p) == 2'b00) begin
            for (int b = 0; b < SW; b++) begin
                if (s[b]) model[m_idx(a)][b*8 +: 8] = d[b*8 +: 8];
            end
        end
    endtask

    task automatic m_clear();
        for (int r = 0; r < NR; r++) model[r] = '0;
    endtask

    // ---------------- transaction drivers ----------------
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                            input logic [2:0] p, input int aw_dly, input int w_dly, input string tag);
        bit aw_f = 1'b0;
        bit w_f = 1'b0;
        int c = 0;
        int n = 0;
        logic [1:0] er;
        @(negedge ACLK);
        BREADY = 1'b1;
        while (!(aw_f && w_f) && c < 40) begin
            if (!aw_f && c >= aw_dly) begin AWVALID = 1'b1; AWADDR = a; AWPROT = p; end
            if (!w_f && c >= w_dly) begin WVALID = 1'b1; WDATA = d; WSTRB = s; end
            if (AWVALID && AWREADY) aw_f = 1'b1;
            if (WVALID && WREADY) w_f = 1'b1;
            @(negedge ACLK);
            c++;
            if (aw_f) AWVALID = 1'b0;
            if (w_f) WVALID = 1'b0;
        end
        checks++;
        if (!(aw_f && w_f)) begin
            failures++;
            $display("FAIL %s write handshake timeout: aw=%0b w=%0b required both 1", tag, aw_f, w_f);
            AWVALID = 1'b0;
            WVALID = 1'b0;
        end else begin
            while (!BVALID && n < 20) begin @(negedge ACLK); n++; end
            er = m_resp(a, p);
            checks++;
            if (n !== 0) begin
                failures++;
                $display("FAIL %s write latency: got %0d extra cycles, required 0", tag, n);
            end
            checks++;
            if (BVALID !== 1'b1 || BRESP !== er) begin
                failures++;
                $display("FAIL %s bresp: bvalid=%0b bresp=%0d, required bvalid=1 bresp=%0d",
                         tag, BVALID, BRESP, er);
            end
            m_write(a, d, s, p);
        end
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [2:0] p, input int rr_dly, input string tag);
        int n = 0;
        logic [DW-1:0] ed;
        logic [1:0] er;
        @(negedge ACLK);
        RREADY = (rr_dly == 0);
        ARVALID = 1'b1;
        ARADDR = a;
        ARPROT = p;
        while (!ARREADY && n < 20) begin @(negedge ACLK); n++; end
        checks++;
        if (n >= 20) begin
            failures++;
            $display("FAIL %s arready timeout: arready=%0b required 1", tag, ARREADY);
        end
        ed = m_read(a, p);
        er = m_resp(a, p);
        @(negedge ACLK);
        ARVALID = 1'b0;
        checks++;
        if (RVALID !== 1'b1 || RDATA !== ed || RRESP !== er) begin
            failures++;
            $display("FAIL %s read: rvalid=%0b rdata=%h rresp=%0d, required 1 %h %0d",
                     tag, RVALID, RDATA, RRESP, ed, er);
        end
        for (int i = 0; i < rr_dly; i++) begin
            @(negedge ACLK);
            checks++;
            if (RVALID !== 1'b1 || RDATA !== ed || RRESP !== er) begin
                failures++;
                $display("FAIL %s read stall: rvalid=%0b rdata=%h rresp=%0d, required 1 %h %0d",
                         tag, RVALID, RDATA, RRESP, ed, er);
            end
        end
        RREADY = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        ARESETn = 1'b0;
        m_clear();
        repeat (2) @(negedge ACLK);
        checks++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0 || BRESP !== OKAY ||
            RRESP !== 2'b00 || RDATA !== '0) begin
            failures++;
            $display("FAIL reset_values: aw/w/ar rdy b/r vld=%b bresp=%0d rresp=%0d rdata=%h, required all 0",
                     {AWREADY, WREADY, ARREADY, BVALID, RVALID}, BRESP, RRESP, RDATA);
        end
        ARESETn = 1'b1;
        #1;
        checks++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin
            failures++;
            $display("FAIL ready_before_rst_done: got %b required 000", {AWREADY, WREADY, ARREADY});
        end
        @(negedge ACLK);
        checks++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
            failures++;
            $display("FAIL ready_after_rst_done: got %b required 111", {AWREADY, WREADY, ARREADY});
        end
    endtask

    task automatic test_same_cycle_write();
        do_write(32'h08, 64'h1122334455667788, 8'hFF, 3'b001, 0, 0, "same_cycle");
        do_read(32'h08, 3'b001, 0, "same_cycle_rd");
    endtask

    task automatic test_w_before_aw();
        logic [DW-1:0] d = {$urandom, $urandom};
        @(negedge ACLK);
        BREADY = 1'b1;
        WVALID = 1'b1; WDATA = d; WSTRB = 8'h0F;
        checks++;
        if (WREADY !== 1'b1) begin
            failures++;
            $display("FAIL wfirst_wready: got %0b required 1", WREADY);
        end
        @(negedge ACLK);
        WVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (WREADY !== 1'b0 || BVALID !== 1'b0) begin
                failures++;
                $display("FAIL wfirst_hold cycle %0d: wready=%0b bvalid=%0b required 0 0", i, WREADY, BVALID);
            end
            if (i < 2) @(negedge ACLK);
        end
        AWVALID = 1'b1; AWADDR = 32'h18; AWPROT = 3'b001;
        @(negedge ACLK);
        AWVALID = 1'b0;
        checks++;
        if (BVALID !== 1'b1 || BRESP !== OKAY || WREADY !== 1'b1) begin
            failures++;
            $display("FAIL wfirst_resp: bvalid=%0b bresp=%0d wready=%0b required 1 0 1", BVALID, BRESP, WREADY);
        end
        m_write(32'h18, d, 8'h0F, 3'b001);
        do_read(32'h18, 3'b001, 1, "wfirst_rd");
    endtask

    task automatic test_b_backpressure();
        logic [DW-1:0] d2 = {$urandom, $urandom};
        logic [SW-1:0] s2 = SW'($urandom);
        @(negedge ACLK);
        BREADY = 1'b0;
        AWVALID = 1'b1; AWADDR = 32'h80; AWPROT = 3'b001;
        WVALID = 1'b1; WDATA = {$urandom, $urandom}; WSTRB = 8'hFF;
        @(negedge ACLK);
        AWADDR = 32'h28; WDATA = d2; WSTRB = s2;
        checks++;
        if (BVALID !== 1'b1 || BRESP !== DECERR) begin
            failures++;
            $display("FAIL bp_first_resp: bvalid=%0b bresp=%0d required 1 3", BVALID, BRESP);
        end
        @(negedge ACLK);
        AWVALID = 1'b0;
        WVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (BVALID !== 1'b1 || BRESP !== DECERR || AWREADY !== 1'b0 || WREADY !== 1'b0) begin
                failures++;
                $display("FAIL bp_stall cycle %0d: bvalid=%0b bresp=%0d awready=%0b wready=%0b required 1 3 0 0",
                         i, BVALID, BRESP, AWREADY, WREADY);
            end
            if (i == 2) BREADY = 1'b1;
            else @(negedge ACLK);
        end
        @(negedge ACLK);
        checks++;
        if (BVALID !== 1'b1 || BRESP !== OKAY || AWREADY !== 1'b1) begin
            failures++;
            $display("FAIL bp_second_resp: bvalid=%0b bresp=%0d awready=%0b required 1 0 1", BVALID, BRESP, AWREADY);
        end
        m_write(32'h28, d2, s2, 3'b001);
        @(negedge ACLK);
        checks++;
        if (BVALID !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain: bvalid=%0b required 0", BVALID);
        end
        do_read(32'h28, 3'b001, 0, "bp_rd");
    endtask

    task automatic test_out_of_range();
        do_read(32'h80, 3'b001, 0, "oor_rd");
        do_write(32'h80, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 3'b001, 0, 0, "oor_wr");
        do_write(32'h1000_0000, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF, 3'b001, 1, 0, "oor_wr_hi");
        for (int r = 0; r < NR; r++) do_read(AW'(r * SW), 3'b001, 0, "oor_scan");
    endtask

    task automatic test_prot();
        do_write(32'h00, 64'h0123_4567_89AB_CDEF, 8'hFF, 3'b000, 0, 0, "prot_unpriv_wr");
        do_read(32'h00, 3'b001, 0, "prot_rd1");
        do_write(32'h00, 64'hFEDC_BA98_7654_3210, 8'hFF, 3'b001, 0, 0, "prot_priv_wr");
        do_read(32'h00, 3'b000, 0, "prot_unpriv_rd");
        do_read(32'h00, 3'b001, 0, "prot_rd2");
    endtask

    task automatic test_concurrent();
        logic [DW-1:0] d = {$urandom, $urandom};
        logic [DW-1:0] old = model[5];
        @(negedge ACLK);
        BREADY = 1'b1; RREADY = 1'b1;
        AWVALID = 1'b1; AWADDR = 32'h28; AWPROT = 3'b001;
        WVALID = 1'b1; WDATA = d; WSTRB = 8'hFF;
        ARVALID = 1'b1; ARADDR = 32'h28; ARPROT = 3'b001;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        checks++;
        if (RVALID !== 1'b1 || RDATA !== old || RRESP !== 2'b00) begin
            failures++;
            $display("FAIL concurrent_old: rvalid=%0b rdata=%h rresp=%0d required 1 %h 0", RVALID, RDATA, RRESP, old);
        end
        checks++;
        if (BVALID !== 1'b1 || BRESP !== OKAY) begin
            failures++;
            $display("FAIL concurrent_b: bvalid=%0b bresp=%0d required 1 0", BVALID, BRESP);
        end
        m_write(32'h28, d, 8'hFF, 3'b001);
        do_read(32'h28, 3'b001, 0, "concurrent_new");
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        @(negedge ACLK);
        BREADY = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = AW'($urandom_range(0, NR - 1) * SW);
            d = {$urandom, $urandom};
            s = SW'($urandom);
            AWVALID = 1'b1; AWADDR = a; AWPROT = 3'b001;
            WVALID = 1'b1; WDATA = d; WSTRB = s;
            checks++;
            if (AWREADY !== 1'b1 || WREADY !== 1'b1 || (i > 0 && (BVALID !== 1'b1 || BRESP !== OKAY))) begin
                failures++;
                $display("FAIL b2b beat %0d: awready=%0b wready=%0b bvalid=%0b bresp=%0d required 1 1 1 0",
                         i, AWREADY, WREADY, BVALID, BRESP);
            end
            m_write(a, d, s, 3'b001);
            @(negedge ACLK);
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        checks++;
        if (BVALID !== 1'b1) begin
            failures++;
            $display("FAIL b2b_last: bvalid=%0b required 1", BVALID);
        end
        @(negedge ACLK);
        checks++;
        if (BVALID !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: bvalid=%0b required 0", BVALID);
        end
        for (int r = 0; r < NR; r += 3) do_read(AW'(r * SW), 3'b001, 0, "b2b_rd");
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++) begin
            logic [AW-1:0] a = AW'($urandom_range(0, NR * SW + 31));
            logic [2:0] p = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1)
                do_write(a, {$urandom, $urandom}, SW'($urandom), p,
                         $urandom_range(0, 3), $urandom_range(0, 3), "rand_wr");
            else
                do_read(a, p, $urandom_range(0, 2), "rand_rd");
        end
    endtask

    task automatic test_reset_mid();
        do_write(32'h08, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, 3'b001, 0, 0, "rstmid_pre");
        @(negedge ACLK);
        RREADY = 1'b0;
        ARVALID = 1'b1; ARADDR = 32'h08; ARPROT = 3'b001;
        @(negedge ACLK);
        ARVALID = 1'b0;
        BREADY = 1'b0;
        AWVALID = 1'b1; AWADDR = 32'h10; AWPROT = 3'b001;
        WVALID = 1'b1; WDATA = 64'h5555; WSTRB = 8'hFF;
        @(negedge ACLK);
        WVALID = 1'b0;
        AWADDR = 32'h18;
        @(negedge ACLK);
        AWVALID = 1'b0;
        checks++;
        if (BVALID !== 1'b1 || AWREADY !== 1'b0 || RVALID !== 1'b1 || RDATA !== 64'hDEAD_BEEF_0BAD_F00D) begin
            failures++;
            $display("FAIL rstmid_setup: bvalid=%0b awready=%0b rvalid=%0b rdata=%h required 1 0 1 deadbeef0badf00d",
                     BVALID, AWREADY, RVALID, RDATA);
        end
        #2;
        ARESETn = 1'b0;
        #1;
        checks++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0 || BRESP !== OKAY ||
            RRESP !== 2'b00 || RDATA !== '0) begin
            failures++;
            $display("FAIL rstmid_async: rdy/vld=%b bresp=%0d rresp=%0d rdata=%h required all 0",
                     {AWREADY, WREADY, ARREADY, BVALID, RVALID}, BRESP, RRESP, RDATA);
        end
        m_clear();
        RREADY = 1'b1;
        BREADY = 1'b1;
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        do_read(32'h08, 3'b001, 0, "rstmid_rd8");
        do_read(32'h10, 3'b001, 0, "rstmid_rd10");
        do_write(32'h20, 64'h77, 8'h01, 3'b001, 0, 1, "rstmid_wr");
        do_read(32'h18, 3'b001, 0, "rstmid_rd18");
        do_read(32'h20, 3'b001, 0, "rstmid_rd20");
    endtask

    initial begin
        test_reset();
        test_same_cycle_write();
        test_w_before_aw();
        test_b_backpressure();
        test_out_of_range();
        test_prot();
        test_concurrent();
        test_back_to_back();
        test_random();
        test_reset_mid();
        repeat (2) @(negedge ACLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
